// File: rtl/timer_pkg.sv
// Shared definitions for the bus-mapped down-counting timer: register offsets,
// CTRL bit positions, MODE encodings and the FSM state type.
package timer_pkg;

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_PRESET = 2'd1;
    localparam logic [1:0] IDX_COUNT  = 2'd2;

    localparam logic [3:0] OFF_CTRL   = {IDX_CTRL,   2'b00};
    localparam logic [3:0] OFF_PRESET = {IDX_PRESET, 2'b00};
    localparam logic [3:0] OFF_COUNT  = {IDX_COUNT,  2'b00};

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} timer_state_e;

    // Only the exact reload encoding reloads; the reserved 1x codes act as one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counting timer with one-shot and auto-reload modes,
// decoded from the bridge's broadcast bus and raising a maskable interrupt.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);
    import timer_pkg::*;

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       preset_q, preset_d;
    logic [31:0]       count_q, count_d;
    logic              pending_q, pending_d;
    timer_state_e      state_q, state_d;

    logic       sel, wr_ctrl, wr_preset;
    logic       en;
    logic [1:0] mode;
    logic       pending_set, pending_rel, en_clr;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    // The bridge does not qualify we by address, so every write is decoded here.
    assign sel       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
    assign wr_ctrl   = we && sel && (addr[3:2] == IDX_CTRL);
    assign wr_preset = we && sel && (addr[3:2] == IDX_PRESET);

    assign en   = ctrl_q[CTRL_EN];
    assign mode = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pending_set = 1'b0;
        pending_rel = 1'b0;
        en_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = LOAD;
            end
            LOAD: begin
                if (en) begin
                    count_d = preset_q;
                    state_d = CNT;
                end else begin
                    state_d = IDLE;
                end
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q == 32'd0) begin
                    state_d     = INT;
                    pending_set = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            INT: begin
                if (is_reload(mode)) begin
                    pending_rel = 1'b1;
                    state_d     = LOAD;
                end else begin
                    en_clr  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A software CTRL write overrides both the one-shot EN clear and any pending update.
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = wd[CTRL_W-1:0];
        end else if (en_clr) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end

        pending_d = pending_q;
        if (wr_ctrl) begin
            pending_d = 1'b0;
        end else if (pending_set) begin
            pending_d = 1'b1;
        end else if (pending_rel) begin
            pending_d = 1'b0;
        end

        preset_d = wr_preset ? wd : preset_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            state_q   <= IDLE;
        end else begin
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        rd = 32'h0;
        if (sel) begin
            case (addr[3:2])
                IDX_CTRL:   rd = {{(32-CTRL_W){1'b0}}, ctrl_q};
                IDX_PRESET: rd = preset_q;
                IDX_COUNT:  rd = count_q;
                default:    rd = 32'h0;
            endcase
        end
    end

    assign irq = pending_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expected values go through a scoreboard
// queue and are compared with immediate assertions half a cycle from the clock edge.
module tb_timer_counter;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_HOLE   = 32'h0000_7F0C;
    localparam logic [31:0] A_OUTSIDE = 32'h0000_7F10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    timer_counter #(.BASE_ADDR(32'h0000_7F00)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .addr   (addr),
        .we     (we),
        .wd     (wd),
        .rd     (rd),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; the write lands on the next rising edge and
    // the task returns at the falling edge after it.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        wd   = 32'h0;
        addr = 32'h0;
    endtask

    task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        sb_t item;
        sb_q.push_back('{tag: tag, exp: e});
        addr = a;
        #1;
        item = sb_q.pop_front();
        checks++;
        assert (rd === item.exp) else begin
            errors++;
            $error("FAIL %s: rd=%h expected %h", item.tag, rd, item.exp);
        end
    endtask

    task automatic check_irq(input string tag, input logic e);
        sb_t item;
        sb_q.push_back('{tag: tag, exp: {31'b0, e}});
        item = sb_q.pop_front();
        checks++;
        assert (irq === item.exp[0]) else begin
            errors++;
            $error("FAIL %s: irq=%b expected %b", item.tag, irq, item.exp[0]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        we      = 1'b0;
        addr    = 32'h0;
        wd      = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_rd("rst_ctrl", A_CTRL, 32'h0);
        check_rd("rst_preset", A_PRESET, 32'h0);
        check_rd("rst_count", A_COUNT, 32'h0);
        check_irq("rst_irq", 1'b0);

        // Register access
        bus_write(A_PRESET, 32'hDEAD_BEEF);
        check_rd("preset_rw", A_PRESET, 32'hDEAD_BEEF);
        bus_write(A_CTRL, 32'hFFFF_FFF0);
        check_rd("ctrl_upper_ignored", A_CTRL, 32'h0);
        bus_write(A_CTRL, 32'h0000_000E);
        check_rd("ctrl_rw", A_CTRL, 32'hE);
        bus_write(A_CTRL, 32'h0);

        // One-shot: PRESET=3, CTRL=EN|IM
        bus_write(A_PRESET, 32'd3);
        bus_write(A_CTRL, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_irq($sformatf("oneshot_irq_e%0d", k), k >= 6);
            if (k >= 2 && k <= 5) check_rd($sformatf("oneshot_count_e%0d", k), A_COUNT, 32'(5 - k));
            if (k == 8) check_rd("oneshot_en_cleared", A_CTRL, 32'h8);
        end
        repeat (3) @(negedge clk);
        check_irq("oneshot_irq_held", 1'b1);
        bus_write(A_CTRL, 32'h9);
        check_irq("oneshot_rearm_clears", 1'b0);
        bus_write(A_CTRL, 32'h0);
        repeat (3) @(negedge clk);

        // Auto-reload: PRESET=2, CTRL=EN|MODE=01|IM -> one-cycle pulse every 5 edges
        bus_write(A_PRESET, 32'd2);
        bus_write(A_CTRL, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check_irq($sformatf("reload_irq_e%0d", k), (k >= 5) && ((k - 5) % 5 == 0));
            if (k == 2 || k == 7) check_rd($sformatf("reload_count_e%0d", k), A_COUNT, 32'd2);
            if (k == 12) check_rd("reload_en_stays", A_CTRL, 32'hB);
        end
        bus_write(A_CTRL, 32'h0);
        repeat (3) @(negedge clk);

        // Masked: CTRL=EN only, interrupt never reaches irq
        bus_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_irq($sformatf("masked_irq_e%0d", k), 1'b0);
            if (k == 4) check_rd("masked_count_zero", A_COUNT, 32'h0);
            if (k == 7) check_rd("masked_en_cleared", A_CTRL, 32'h0);
        end

        // Decode: writes outside the window or to the hole/COUNT change nothing
        bus_write(A_OUTSIDE, 32'hFFFF_FFFF);
        check_rd("decode_outside_ctrl", A_CTRL, 32'h0);
        check_rd("decode_outside_preset", A_PRESET, 32'd2);
        bus_write(A_HOLE, 32'hFFFF_FFFF);
        check_rd("decode_hole_ctrl", A_CTRL, 32'h0);
        check_rd("decode_hole_read", A_HOLE, 32'h0);
        bus_write(A_COUNT, 32'h0000_FFFF);
        check_rd("count_write_ignored", A_COUNT, 32'h0);
        check_rd("count_write_preset", A_PRESET, 32'd2);
        check_rd("outside_read", A_OUTSIDE, 32'h0);

        // PRESET=0: pending three edges after the EN write
        bus_write(A_PRESET, 32'd0);
        bus_write(A_CTRL, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_irq($sformatf("zero_irq_e%0d", k), k >= 3);
            if (k == 2) check_rd("zero_count", A_COUNT, 32'h0);
            if (k == 5) check_rd("zero_en_cleared", A_CTRL, 32'h8);
        end

        // Collision: CTRL write on the edge the one-shot INT clears EN
        bus_write(A_CTRL, 32'h9);
        check_irq("coll_rearm", 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_irq($sformatf("coll_irq_e%0d", k), k == 3);
        end
        bus_write(A_CTRL, 32'hE);
        check_rd("coll_ctrl_wd", A_CTRL, 32'hE);
        check_irq("coll_pending_cleared", 1'b0);
        repeat (4) @(negedge clk);
        check_irq("coll_idle_irq", 1'b0);
        check_rd("coll_idle_ctrl", A_CTRL, 32'hE);

        // Asynchronous reset mid-count
        bus_write(A_PRESET, 32'd10);
        bus_write(A_CTRL, 32'h9);
        repeat (7) @(negedge clk);
        check_rd("midcount_count5", A_COUNT, 32'd5);
        reset_n = 1'b0;
        check_rd("arst_ctrl", A_CTRL, 32'h0);
        check_rd("arst_preset", A_PRESET, 32'h0);
        check_rd("arst_count", A_COUNT, 32'h0);
        check_irq("arst_irq", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_rd("post_rst_count", A_COUNT, 32'h0);
        check_rd("post_rst_ctrl", A_CTRL, 32'h0);
        check_irq("post_rst_irq", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
